// File: rtl/pio_bus_master.sv
// Register-bus master: queues read/write commands in a small FIFO, runs one
// sel/busy access at a time with an optional stall timeout, and returns responses in order.
module pio_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_rw,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sel,
    output logic        RW,
    output logic [11:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        busy,
    output logic [4:0]  fifo_level
);
    localparam int         PW         = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH      = 5'(FIFO_DEPTH);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_next;

    logic          fifo_rw    [FIFO_DEPTH];
    logic [11:0]   fifo_addr  [FIFO_DEPTH];
    logic [31:0]   fifo_wdata [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, done, abort;
    logic          rw_q;
    logic [11:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [7:0]    wait_cnt;

    // No bypass: a full FIFO refuses even when the head is popped this cycle.
    assign cmd_ready = (fifo_level < DEPTH);
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!busy) begin
                    done       = 1'b1;
                    state_next = RESP;
                end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rw[wr_ptr]    <= cmd_rw;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            rsp_rw     <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
            if (pop) begin
                rw_q     <= fifo_rw[rd_ptr];
                addr_q   <= fifo_addr[rd_ptr];
                wdata_q  <= fifo_wdata[rd_ptr];
                wait_cnt <= '0;
            end else if (state == ACCESS && busy) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (done) begin
                rsp_rw    <= rw_q;
                rsp_rdata <= rw_q ? '0 : rdata;
                rsp_err   <= 1'b0;
            end else if (abort) begin
                rsp_rw    <= rw_q;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

    // Bus fields are held in registers but only exposed while sel is high.
    assign sel       = (state == ACCESS);
    assign RW        = sel & rw_q;
    assign addr      = sel ? addr_q : '0;
    assign wdata     = sel ? wdata_q : '0;
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_pio_bus_master.sv
// Self-checking bench for pio_bus_master: directed scenarios plus a randomized
// run checked against a queue-based transaction model.
module tb_pio_bus_master;
    localparam int DEPTH = 4;
    localparam int TO    = 4;

    logic        clk, reset;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_rw, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sel, RW, busy;
    logic [11:0] addr;
    logic [31:0] wdata, rdata;
    logic [4:0]  fifo_level;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] wdata;
        int unsigned stall;
    } cmd_t;

    typedef struct {
        logic        rw;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    pio_bus_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel(sel), .RW(RW), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Responder register contents as seen by the bus.
    function automatic logic [31:0] reg_value(input logic [11:0] a);
        return (a == 12'h0C8) ? 32'hDEAD_BEEF : {a, 8'h5A, ~a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        rdata = reg_value(addr);
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; busy = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [80:0] obs;
        reset = 1'b1; cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'hFFF;
        cmd_wdata = 32'hFFFF_FFFF; rsp_ready = 1'b0; busy = 1'b0;
        step();
        step();
        obs = {sel, RW, addr, wdata, rsp_valid, rsp_rw, rsp_rdata, rsp_err};
        vectors++;
        if (obs !== '0) begin
            miscompares++; $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        vectors++;
        if (cmd_ready !== 1'b1 || fifo_level !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_fifo got ready=%b level=%0d exp ready=1 level=0", cmd_ready, fifo_level);
        end
        reset = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_write();
        do_reset();
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 12'h000; cmd_wdata = 32'h0000_0011;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (sel !== 1'b0 || fifo_level !== 5'd1) begin
            miscompares++; $display("FAIL wr_queued got sel=%b level=%0d exp sel=0 level=1", sel, fifo_level);
        end
        step();
        vectors++;
        if ({sel, RW, addr, wdata} !== {1'b1, 1'b1, 12'h000, 32'h0000_0011}) begin
            miscompares++;
            $display("FAIL wr_issue got sel=%b RW=%b addr=%h wdata=%h exp 1 1 000 00000011", sel, RW, addr, wdata);
        end
        step();
        vectors++;
        if ({sel, RW, addr, wdata} !== '0) begin
            miscompares++; $display("FAIL wr_bus_idle got sel=%b RW=%b addr=%h wdata=%h exp 0", sel, RW, addr, wdata);
        end
        vectors++;
        if ({rsp_valid, rsp_rw, rsp_rdata, rsp_err} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_rsp got v=%b rw=%b rdata=%h err=%b exp 1 1 0 0", rsp_valid, rsp_rw, rsp_rdata, rsp_err);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rw !== 1'b1) begin
            miscompares++; $display("FAIL wr_rsp_hold got v=%b rw=%b exp 1 1", rsp_valid, rsp_rw);
        end
        rsp_ready = 1'b1;
        step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL wr_rsp_taken got v=%b exp 0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_read_busy();
        int n, bz, cyc;
        do_reset();
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h0C8; cmd_wdata = $urandom;
        step();
        cmd_valid = 1'b0;
        n = 0; bz = 0; cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
            if (sel === 1'b1) begin
                n++;
                vectors++;
                if (addr !== 12'h0C8 || RW !== 1'b0) begin
                    miscompares++; $display("FAIL rd_addr_stable got addr=%h RW=%b exp 0c8 0", addr, RW);
                end
                busy = (bz < 3);
                if (busy) bz++;
            end else begin
                busy = 1'b0;
            end
        end
        vectors++;
        if (n != 4) begin
            miscompares++; $display("FAIL rd_sel_cycles got=%0d exp=4", n);
        end
        vectors++;
        if ({rsp_valid, rsp_rw, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_rsp got v=%b rw=%b rdata=%h err=%b exp 1 0 deadbeef 0", rsp_valid, rsp_rw, rsp_rdata, rsp_err);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        cmd_t c [6];
        int   k, cyc;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            c[i].rw = 1'(i % 2); c[i].addr = 12'($urandom); c[i].wdata = $urandom; c[i].stall = 0;
        end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_rw = c[i].rw; cmd_addr = c[i].addr; cmd_wdata = c[i].wdata;
            vectors++;
            if (cmd_ready !== 1'b1) begin
                miscompares++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, cmd_ready);
            end
            step();
        end
        cmd_rw = c[5].rw; cmd_addr = c[5].addr; cmd_wdata = c[5].wdata;
        vectors++;
        if (cmd_ready !== 1'b0 || fifo_level !== 5'd4 || rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_full got ready=%b level=%0d v=%b exp 0 4 1", cmd_ready, fifo_level, rsp_valid);
        end
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (fifo_level !== 5'd4) begin
            miscompares++; $display("FAIL b2b_push_full got level=%0d exp 4", fifo_level);
        end
        rsp_ready = 1'b1;
        k = 0; cyc = 0;
        while (k < 5 && cyc < 60) begin
            if (rsp_valid === 1'b1) begin
                vectors++;
                if (rsp_rw !== c[k].rw || rsp_err !== 1'b0 ||
                    rsp_rdata !== (c[k].rw ? 32'h0 : reg_value(c[k].addr))) begin
                    miscompares++;
                    $display("FAIL b2b_rsp_%0d got rw=%b rdata=%h err=%b exp rw=%b rdata=%h err=0", k, rsp_rw,
                             rsp_rdata, rsp_err, c[k].rw, c[k].rw ? 32'h0 : reg_value(c[k].addr));
                end
                k++;
            end
            step();
            cyc++;
        end
        vectors++;
        if (k != 5) begin
            miscompares++; $display("FAIL b2b_count got=%0d exp=5", k);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n, cyc;
        do_reset();
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h123; cmd_wdata = 32'h0;
        step();
        cmd_rw = 1'b1; cmd_addr = 12'h456; cmd_wdata = 32'hCAFE_0042; busy = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0; cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            if (sel === 1'b1) begin
                n++;
                vectors++;
                if (addr !== 12'h123) begin
                    miscompares++; $display("FAIL to_addr got=%h exp=123", addr);
                end
            end
            step();
            cyc++;
        end
        vectors++;
        if (n != TO) begin
            miscompares++; $display("FAIL to_sel_cycles got=%0d exp=%0d", n, TO);
        end
        vectors++;
        if ({sel, rsp_valid, rsp_rw, rsp_rdata, rsp_err} !== {1'b0, 1'b1, 1'b0, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL to_rsp got sel=%b v=%b rw=%b rdata=%h err=%b exp 0 1 0 0 1", sel, rsp_valid, rsp_rw,
                     rsp_rdata, rsp_err);
        end
        busy = 1'b0; rsp_ready = 1'b1;
        step();
        step();
        vectors++;
        if ({sel, RW, addr, wdata} !== {1'b1, 1'b1, 12'h456, 32'hCAFE_0042}) begin
            miscompares++;
            $display("FAIL to_next_issue got sel=%b RW=%b addr=%h wdata=%h exp 1 1 456 cafe0042", sel, RW, addr, wdata);
        end
        step();
        vectors++;
        if ({rsp_valid, rsp_rw, rsp_rdata, rsp_err} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL to_next_rsp got v=%b rw=%b rdata=%h err=%b exp 1 1 0 0", rsp_valid, rsp_rw, rsp_rdata, rsp_err);
        end
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        busy = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_rw = 1'(i % 2); cmd_addr = 12'(i + 16); cmd_wdata = $urandom;
            step();
        end
        cmd_valid = 1'b0;
        vectors++;
        if (sel !== 1'b1 || fifo_level !== 5'd2) begin
            miscompares++; $display("FAIL rst_mid_pre got sel=%b level=%0d exp 1 2", sel, fifo_level);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; busy = 1'b0; rsp_ready = 1'b1;
        vectors++;
        if (sel !== 1'b0 || fifo_level !== 5'd0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_post got sel=%b level=%0d v=%b exp 0 0 0", sel, fifo_level, rsp_valid);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (rsp_valid !== 1'b0 || sel !== 1'b0) begin
                miscompares++; $display("FAIL rst_mid_quiet_%0d got v=%b sel=%b exp 0 0", i, rsp_valid, sel);
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        int n;
        do_reset();
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_rw = 1'b0; cmd_addr = 12'(i + 32); cmd_wdata = '0;
            step();
        end
        cmd_valid = 1'b0;
        vectors++;
        if (fifo_level !== 5'd2 || rsp_valid !== 1'b1) begin
            miscompares++; $display("FAIL pp_setup got level=%0d v=%b exp 2 1", fifo_level, rsp_valid);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        vectors++;
        if (fifo_level !== 5'd2 || rsp_valid !== 1'b0 || sel !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_idle got level=%0d v=%b sel=%b exp 2 0 0", fifo_level, rsp_valid, sel);
        end
        cmd_valid = 1'b1; cmd_addr = 12'h040;
        step();
        cmd_valid = 1'b0;
        vectors++;
        if (fifo_level !== 5'd2 || sel !== 1'b1) begin
            miscompares++; $display("FAIL pp_level got level=%0d sel=%b exp 2 1", fifo_level, sel);
        end
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid === 1'b1) n++;
        end
        vectors++;
        if (n != 3) begin
            miscompares++; $display("FAIL pp_drain got=%0d exp=3", n);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        cmd_t        iq [$];
        rsp_t        rq [$];
        cmd_t        cur, nc;
        rsp_t        er;
        bit          in_txn;
        int unsigned stall_left;
        do_reset();
        in_txn = 1'b0; stall_left = 0;
        cur = '{rw: 1'b0, addr: '0, wdata: '0, stall: 0};
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (sel === 1'b1) begin
                if (!in_txn) begin
                    vectors++;
                    if (iq.size() == 0) begin
                        miscompares++; $display("FAIL rnd_issue_empty got sel=1 exp no pending command");
                    end else begin
                        cur = iq.pop_front();
                        stall_left = cur.stall;
                    end
                    in_txn = 1'b1;
                end
                vectors++;
                if (RW !== cur.rw || addr !== cur.addr || (cur.rw && wdata !== cur.wdata)) begin
                    miscompares++;
                    $display("FAIL rnd_bus got RW=%b addr=%h wdata=%h exp RW=%b addr=%h wdata=%h", RW, addr, wdata,
                             cur.rw, cur.addr, cur.wdata);
                end
            end else begin
                in_txn = 1'b0;
                vectors++;
                if ({RW, addr, wdata} !== '0) begin
                    miscompares++; $display("FAIL rnd_bus_zero got RW=%b addr=%h wdata=%h exp 0", RW, addr, wdata);
                end
            end
            vectors++;
            if (fifo_level !== 5'(iq.size()) || cmd_ready !== (iq.size() < DEPTH)) begin
                miscompares++;
                $display("FAIL rnd_level got level=%0d ready=%b exp level=%0d", fifo_level, cmd_ready, iq.size());
            end
            busy = (sel === 1'b1) && (stall_left > 0);
            if (busy) stall_left--;
            rsp_ready = (cyc < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid === 1'b1 && rsp_ready) begin
                vectors++;
                if (rq.size() == 0) begin
                    miscompares++; $display("FAIL rnd_rsp_extra got rsp_valid=1 exp no outstanding response");
                end else begin
                    er = rq.pop_front();
                    if (rsp_rw !== er.rw || rsp_rdata !== er.rdata || rsp_err !== er.err) begin
                        miscompares++;
                        $display("FAIL rnd_rsp got rw=%b rdata=%h err=%b exp rw=%b rdata=%h err=%b", rsp_rw,
                                 rsp_rdata, rsp_err, er.rw, er.rdata, er.err);
                    end
                end
            end
            cmd_valid = (cyc < 500) && ($urandom_range(0, 2) != 0);
            nc.rw = 1'($urandom_range(0, 1)); nc.addr = 12'($urandom); nc.wdata = $urandom;
            nc.stall = $urandom_range(0, 5);
            cmd_rw = nc.rw; cmd_addr = nc.addr; cmd_wdata = nc.wdata;
            if (cmd_valid && cmd_ready === 1'b1) begin
                iq.push_back(nc);
                er.err   = (nc.stall >= TO);
                er.rw    = nc.rw;
                er.rdata = (er.err || nc.rw) ? 32'h0 : reg_value(nc.addr);
                rq.push_back(er);
            end
            step();
        end
        cmd_valid = 1'b0;
        vectors++;
        if (rq.size() != 0 || iq.size() != 0) begin
            miscompares++; $display("FAIL rnd_drain got pending rsp=%0d cmd=%0d exp 0 0", rq.size(), iq.size());
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_busy();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        test_push_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pio_bus_master.md
PIO_BUS_MASTER -- requirements
Module: pio_bus_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of busy cycles before abort; 0 disables the timeout.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit, the command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit, the command FIFO not full.
REQ-007 SHALL have port cmd_rw, input, 1 bit, the command type: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr, input, 12 bits, the register address.
REQ-009 SHALL have port cmd_wdata, input, 32 bits, the write data (ignored for reads).
REQ-010 SHALL have port rsp_valid, output, 1 bit, a response available.
REQ-011 SHALL have port rsp_ready, input, 1 bit, the consumer accepts the response.
REQ-012 SHALL have port rsp_rw, output, 1 bit, the type of the completed command.
REQ-013 SHALL have port rsp_rdata, output, 32 bits, the read data (0 for writes and errors).
REQ-014 SHALL have port rsp_err, output, 1 bit, set when the access was aborted by timeout.
REQ-015 SHALL have port sel, output, 1 bit, the register-bus access strobe.
REQ-016 SHALL have port RW, output, 1 bit, the register-bus direction: 1 = write.
REQ-017 SHALL have port addr, output, 12 bits, the register-bus address.
REQ-018 SHALL have port wdata, output, 32 bits, the register-bus write data.
REQ-019 SHALL have port rdata, input, 32 bits, the register-bus read data.
REQ-020 SHALL have port busy, input, 1 bit, the responder stall; an access completes only on an edge where sel=1 and busy=0.
REQ-021 SHALL have port fifo_level, output, 5 bits, the number of queued commands.

Function
REQ-022 SHALL push the command into the FIFO on each edge with cmd_valid=1 and cmd_ready=1; cmd_ready = (fifo_level < FIFO_DEPTH), with no same-cycle pop bypass when full.
REQ-023 SHALL leave fifo_level unchanged on a simultaneous push and pop, and SHALL NOT change state on a pop when empty or a push when full.
REQ-024 SHALL use an FSM with states IDLE, ACCESS and RESP.
REQ-025 In IDLE with the FIFO non-empty, SHALL pop the head, register RW/addr/wdata, assert sel, and go to ACCESS on the same edge.
REQ-026 In ACCESS, SHALL hold sel=1 and hold RW/addr/wdata stable.
REQ-027 On an ACCESS edge with busy=0, SHALL capture rdata (read) or 0 (write) into rsp_rdata, clear rsp_err, deassert sel, and go to RESP.
REQ-028 On an ACCESS edge with busy=1, SHALL increment the 8-bit wait counter.
REQ-029 When TIMEOUT!=0 and the counter equals TIMEOUT-1 on an edge where busy=1, SHALL set rsp_err=1, set rsp_rdata=0, deassert sel, and go to RESP.
REQ-030 SHALL clear the wait counter on entry to ACCESS.
REQ-031 In RESP, SHALL hold rsp_valid=1 with rsp_rw/rsp_rdata/rsp_err stable until an edge with rsp_ready=1, then go to IDLE.
REQ-032 SHALL let the FIFO continue accepting commands in every state.
REQ-033 SHALL drive addr, wdata and RW to 0 whenever sel=0.
REQ-034 Minimum latency: a command accepted at edge N into an empty FIFO gives sel=1 after edge N+1; with busy=0, rsp_valid=1 after edge N+2.
REQ-035 Minimum issue spacing SHALL be 3 cycles per transaction (IDLE, ACCESS, RESP).
REQ-036 SHALL generate exactly one response per accepted command, in command order.

Reset
REQ-037 On reset=1 at an edge, SHALL go to IDLE and flush the FIFO (fifo_level=0), giving sel=0, RW=0, addr=0, wdata=0, rsp_valid=0, rsp_rw=0, rsp_rdata=0, rsp_err=0 and cmd_ready=1.
REQ-038 Reset during ACCESS or RESP SHALL drop the in-flight transaction without emitting a response.

Verification
REQ-039 Bench SHALL cover: write addr=0x000 wdata=0x0000_0011, busy=0 -> sel high exactly 1 cycle with RW=1; response rsp_rw=1, rsp_rdata=0, rsp_err=0.
REQ-040 Bench SHALL cover: read addr=0x0C8 with busy=1 for 3 cycles and rdata=0xDEAD_BEEF -> sel high 4 cycles with addr stable; rsp_rdata=0xDEAD_BEEF.
REQ-041 Bench SHALL cover: 5 back-to-back commands with rsp_ready=0 -> cmd_ready=0 once 4 commands are queued behind the in-flight one; all 5 responses delivered in order after rsp_ready=1.
REQ-042 Bench SHALL cover: TIMEOUT=4 with busy stuck at 1 -> sel high 4 cycles, then rsp_err=1, rsp_rdata=0; the next queued command then issues normally.
REQ-043 Bench SHALL cover: reset asserted mid-ACCESS with 2 commands queued -> next cycle sel=0, fifo_level=0, and no rsp_valid afterwards.
REQ-044 Bench SHALL cover: simultaneous push and pop at fifo_level=2 -> level stays 2.
